// File: rtl/dfdd_pkg.sv
// Shared definitions for the DFDD result packer: FIFO entry field layout and
// coordinate-width helper.
package dfdd_pkg;

    // Entry layout, LSB first: v | w | c | conf_ok | col | row
    localparam int unsigned V_LSB = 0;

    function automatic int unsigned coord_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned w_lsb(input int unsigned fp_w);
        return fp_w;
    endfunction

    function automatic int unsigned c_lsb(input int unsigned fp_w);
        return 2 * fp_w;
    endfunction

    function automatic int unsigned ok_lsb(input int unsigned fp_w);
        return 3 * fp_w;
    endfunction

    function automatic int unsigned col_lsb(input int unsigned fp_w);
        return 3 * fp_w + 1;
    endfunction

    function automatic int unsigned row_lsb(input int unsigned fp_w, input int unsigned col_w);
        return 3 * fp_w + 1 + col_w;
    endfunction

    function automatic int unsigned entry_width(input int unsigned fp_w,
                                                input int unsigned col_w,
                                                input int unsigned row_w);
        return 3 * fp_w + 1 + col_w + row_w;
    endfunction

endpackage

// File: rtl/dfdd_sync_fifo.sv
// Single-clock show-ahead FIFO; a push while full is accepted only when a pop
// happens on the same edge. Storage is not reset.
module dfdd_sync_fifo
    import dfdd_pkg::*;
#(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 2,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_c;
    logic             pop_c;

    always_comb begin
        full_o   = (count_q == CNT_W'(DEPTH));
        empty_o  = (count_q == '0);
        pop_c    = rd_en_i && !empty_o;
        push_c   = wr_en_i && (!full_o || pop_c);
        wr_ptr_d = wr_ptr_q + PTR_W'(push_c);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_c);
        count_d  = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_ptr_q];
    assign count_o   = count_q;

endmodule

// File: rtl/dfdd_result_packer.sv
// Tags hardmax results with confidence flag and frame coordinates and queues
// them in a show-ahead FIFO for a downstream consumer.
module dfdd_result_packer
    import dfdd_pkg::*;
#(
    parameter int unsigned EXP_WIDTH    = 0,
    parameter int unsigned FRAC_WIDTH   = 0,
    parameter int unsigned FIFO_DEPTH   = 16,
    parameter int unsigned IMAGE_WIDTH  = 0,
    parameter int unsigned IMAGE_HEIGHT = 0,
    localparam int unsigned FP_WIDTH_REG = 1 + FRAC_WIDTH + EXP_WIDTH,
    localparam int unsigned COL_W        = coord_width(IMAGE_WIDTH),
    localparam int unsigned ROW_W        = coord_width(IMAGE_HEIGHT),
    localparam int unsigned CNT_W        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [FP_WIDTH_REG-1:0] v_i,
    input  logic [FP_WIDTH_REG-1:0] w_i,
    input  logic [FP_WIDTH_REG-1:0] c_i,
    input  logic                    valid_i,
    input  logic [FP_WIDTH_REG-1:0] c_thresh_i,
    input  logic                    frame_sync_i,
    output logic [FP_WIDTH_REG-1:0] v_o,
    output logic [FP_WIDTH_REG-1:0] w_o,
    output logic [FP_WIDTH_REG-1:0] c_o,
    output logic                    conf_ok_o,
    output logic [COL_W-1:0]        col_o,
    output logic [ROW_W-1:0]        row_o,
    output logic                    sof_o,
    output logic                    eol_o,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic [CNT_W-1:0]        fifo_count_o,
    output logic                    overflow_o
);

    localparam int unsigned FP       = FP_WIDTH_REG;
    localparam int unsigned W_LSB    = w_lsb(FP);
    localparam int unsigned C_LSB    = c_lsb(FP);
    localparam int unsigned OK_LSB   = ok_lsb(FP);
    localparam int unsigned COL_LSB  = col_lsb(FP);
    localparam int unsigned ROW_LSB  = row_lsb(FP, COL_W);
    localparam int unsigned ENTRY_W  = entry_width(FP, COL_W, ROW_W);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMAGE_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMAGE_HEIGHT - 1);

    logic            s1_valid_q, s1_valid_d;
    logic [FP-1:0]   s1_v_q, s1_v_d;
    logic [FP-1:0]   s1_w_q, s1_w_d;
    logic [FP-1:0]   s1_c_q, s1_c_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic            overflow_q, overflow_d;
    logic [COL_W-1:0] pix_col_c;
    logic [ROW_W-1:0] pix_row_c;
    logic            conf_ok_c;
    logic [ENTRY_W-1:0] wr_data_c;
    logic [ENTRY_W-1:0] rd_data_c;
    logic            fifo_full_c;
    logic            fifo_empty_c;
    logic            pop_c;

    always_comb begin
        s1_valid_d = valid_i;
        s1_v_d     = v_i;
        s1_w_d     = w_i;
        s1_c_d     = c_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
        end
    end

    always_ff @(posedge clk_i) begin
        s1_v_q <= s1_v_d;
        s1_w_q <= s1_w_d;
        s1_c_q <= s1_c_d;
    end

    // frame_sync forces this pixel to (0,0); the counters then advance from there
    always_comb begin
        pix_col_c = frame_sync_i ? '0 : col_q;
        pix_row_c = frame_sync_i ? '0 : row_q;
        col_d     = pix_col_c;
        row_d     = pix_row_c;
        if (s1_valid_q) begin
            if (pix_col_c == COL_LAST) begin
                col_d = '0;
                row_d = (pix_row_c == ROW_LAST) ? '0 : pix_row_c + ROW_W'(1);
            end else begin
                col_d = pix_col_c + COL_W'(1);
            end
        end
    end

    // Inputs are non-negative floats, so an unsigned compare orders them correctly
    always_comb begin
        conf_ok_c = (s1_c_q >= c_thresh_i);
        wr_data_c = '0;
        wr_data_c[V_LSB +: FP]      = s1_v_q;
        wr_data_c[W_LSB +: FP]      = s1_w_q;
        wr_data_c[C_LSB +: FP]      = s1_c_q;
        wr_data_c[OK_LSB]           = conf_ok_c;
        wr_data_c[COL_LSB +: COL_W] = pix_col_c;
        wr_data_c[ROW_LSB +: ROW_W] = pix_row_c;
    end

    always_comb begin
        pop_c      = !fifo_empty_c && ready_i;
        overflow_d = overflow_q | (s1_valid_q & fifo_full_c & ~pop_c);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            col_q      <= '0;
            row_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            col_q      <= col_d;
            row_q      <= row_d;
            overflow_q <= overflow_d;
        end
    end

    dfdd_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .wr_en_i   (s1_valid_q),
        .wr_data_i (wr_data_c),
        .rd_en_i   (pop_c),
        .rd_data_o (rd_data_c),
        .full_o    (fifo_full_c),
        .empty_o   (fifo_empty_c),
        .count_o   (fifo_count_o)
    );

    always_comb begin
        v_o        = rd_data_c[V_LSB +: FP];
        w_o        = rd_data_c[W_LSB +: FP];
        c_o        = rd_data_c[C_LSB +: FP];
        conf_ok_o  = rd_data_c[OK_LSB];
        col_o      = rd_data_c[COL_LSB +: COL_W];
        row_o      = rd_data_c[ROW_LSB +: ROW_W];
        sof_o      = (col_o == '0) && (row_o == '0);
        eol_o      = (col_o == COL_LAST);
        valid_o    = !fifo_empty_c;
        overflow_o = overflow_q;
    end

endmodule

// File: tb/tb_dfdd_result_packer.sv
// Randomized + directed bench for dfdd_result_packer against a queue-based
// reference model using linear frame positions.
module tb_dfdd_result_packer;

    localparam int unsigned IW = 4;
    localparam int unsigned IH = 2;
    localparam int unsigned D  = 4;
    localparam int unsigned NPIX = IW * IH;
    localparam logic [31:0] THRESH = 32'h3F00_0000;

    logic        clk;
    logic        rst_i;
    logic [31:0] v_i, w_i, c_i;
    logic        valid_i;
    logic [31:0] c_thresh_i;
    logic        frame_sync_i;
    logic [31:0] v_o, w_o, c_o;
    logic        conf_ok_o;
    logic [1:0]  col_o;
    logic [0:0]  row_o;
    logic        sof_o, eol_o, valid_o;
    logic        ready_i;
    logic [2:0]  fifo_count_o;
    logic        overflow_o;

    dfdd_result_packer #(
        .EXP_WIDTH    (8),
        .FRAC_WIDTH   (23),
        .FIFO_DEPTH   (D),
        .IMAGE_WIDTH  (IW),
        .IMAGE_HEIGHT (IH)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .v_i          (v_i),
        .w_i          (w_i),
        .c_i          (c_i),
        .valid_i      (valid_i),
        .c_thresh_i   (c_thresh_i),
        .frame_sync_i (frame_sync_i),
        .v_o          (v_o),
        .w_o          (w_o),
        .c_o          (c_o),
        .conf_ok_o    (conf_ok_o),
        .col_o        (col_o),
        .row_o        (row_o),
        .sof_o        (sof_o),
        .eol_o        (eol_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .fifo_count_o (fifo_count_o),
        .overflow_o   (overflow_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] v, w, c;
        logic        ok;
        int          col, row;
    } entry_t;

    entry_t      q[$];
    logic        m_s1_valid;
    logic [31:0] m_s1_v, m_s1_w, m_s1_c;
    int          m_pos;
    logic        m_ovf;
    int          total = 0;
    int          bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference behaviour at one clock edge, from the pre-edge model state
    task automatic model_edge();
        entry_t e;
        logic   pop;
        int     p;
        if (rst_i) begin
            q.delete();
            m_s1_valid = 1'b0;
            m_pos      = 0;
            m_ovf      = 1'b0;
            return;
        end
        pop = (q.size() > 0) && ready_i;
        p   = frame_sync_i ? 0 : m_pos;
        if (m_s1_valid) begin
            e.v   = m_s1_v;
            e.w   = m_s1_w;
            e.c   = m_s1_c;
            e.ok  = (m_s1_c >= c_thresh_i);
            e.col = p % IW;
            e.row = p / IW;
        end
        m_pos = m_s1_valid ? (p + 1) % NPIX : p;
        if (pop) void'(q.pop_front());
        if (m_s1_valid) begin
            if (q.size() < D) q.push_back(e);
            else m_ovf = 1'b1;
        end
        m_s1_valid = valid_i;
        m_s1_v     = v_i;
        m_s1_w     = w_i;
        m_s1_c     = c_i;
    endtask

    task automatic check_outputs();
        entry_t e;
        check_eq("valid_o", 32'(valid_o), 32'(q.size() != 0));
        check_eq("count", 32'(fifo_count_o), 32'(q.size()));
        check_eq("overflow", 32'(overflow_o), 32'(m_ovf));
        if (q.size() != 0) begin
            e = q[0];
            check_eq("v", v_o, e.v);
            check_eq("w", w_o, e.w);
            check_eq("c", c_o, e.c);
            check_eq("conf_ok", 32'(conf_ok_o), 32'(e.ok));
            check_eq("col", 32'(col_o), 32'(e.col));
            check_eq("row", 32'(row_o), 32'(e.row));
            check_eq("sof", 32'(sof_o), 32'(e.col == 0 && e.row == 0));
            check_eq("eol", 32'(eol_o), 32'(e.col == IW - 1));
        end
    endtask

    task automatic step(input logic vi, input logic [31:0] c, input logic rdy,
                        input logic fs, input logic rst);
        valid_i      = vi;
        v_i          = $urandom;
        w_i          = $urandom;
        c_i          = c;
        ready_i      = rdy;
        frame_sync_i = fs;
        rst_i        = rst;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    function automatic logic [31:0] rand_c();
        case ($urandom_range(3))
            0:       return THRESH - 32'd1;
            1:       return THRESH;
            2:       return THRESH + 32'd1;
            default: return $urandom & 32'h7FFF_FFFF;
        endcase
    endfunction

    initial begin
        rst_i = 1'b1; valid_i = 1'b0; v_i = '0; w_i = '0; c_i = '0;
        ready_i = 1'b0; frame_sync_i = 1'b0; c_thresh_i = THRESH;
        q.delete(); m_s1_valid = 1'b0; m_pos = 0; m_ovf = 1'b0;
        m_s1_v = '0; m_s1_w = '0; m_s1_c = '0;
        @(negedge clk);

        step(0, 0, 1, 0, 1);
        step(0, 0, 1, 0, 1);

        // single pixel, two-cycle latency, one-cycle visibility
        step(1, 32'h3F80_0000, 1, 0, 0);
        check_eq("lat_edge0", 32'(valid_o), 32'd0);
        step(0, 0, 1, 0, 0);
        check_eq("lat_edge1", 32'(valid_o), 32'd1);
        check_eq("single_sof", 32'(sof_o), 32'd1);
        step(0, 0, 1, 0, 0);
        check_eq("single_gone", 32'(valid_o), 32'd0);

        // threshold boundary
        step(0, 0, 1, 0, 1);
        step(1, 32'h3E80_0000, 1, 0, 0);
        step(1, 32'h3F00_0000, 1, 0, 0);
        check_eq("below_thresh", 32'(conf_ok_o), 32'd0);
        step(0, 0, 1, 0, 0);
        check_eq("at_thresh", 32'(conf_ok_o), 32'd1);
        step(0, 0, 1, 0, 0);

        // full frame streaming
        step(0, 0, 1, 0, 1);
        for (int i = 0; i < 8; i++) step(1, rand_c(), 1, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0);

        // overflow with stalled consumer, then drain
        step(0, 0, 1, 0, 1);
        for (int i = 0; i < 6; i++) step(1, rand_c(), 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        check_eq("ovf_count", 32'(fifo_count_o), 32'd4);
        check_eq("ovf_flag", 32'(overflow_o), 32'd1);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0);
        step(1, rand_c(), 1, 0, 0);
        step(0, 0, 1, 0, 0);
        check_eq("after_drop_col", 32'(col_o), 32'd2);
        check_eq("after_drop_row", 32'(row_o), 32'd1);
        step(0, 0, 1, 0, 0);

        // full with simultaneous pop and push
        step(0, 0, 1, 0, 1);
        for (int i = 0; i < 4; i++) step(1, rand_c(), 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(1, rand_c(), 0, 0, 0);
        step(0, 0, 1, 0, 0);
        check_eq("full_pp_count", 32'(fifo_count_o), 32'd4);
        check_eq("full_pp_ovf", 32'(overflow_o), 32'd0);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 0);

        // reset with queued entries
        step(0, 0, 1, 0, 1);
        for (int i = 0; i < 3; i++) step(1, rand_c(), 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        check_eq("rst_valid", 32'(valid_o), 32'd0);
        check_eq("rst_count", 32'(fifo_count_o), 32'd0);
        step(1, rand_c(), 1, 0, 0);
        step(0, 0, 1, 0, 0);
        check_eq("post_rst_sof", 32'(sof_o), 32'd1);

        // frame_sync coinciding with an s1 pixel, and alone
        for (int i = 0; i < 3; i++) step(1, rand_c(), 1, 0, 0);
        step(1, rand_c(), 1, 1, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 1, 0);
        step(1, rand_c(), 1, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0);

        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(99) < 70, rand_c(), $urandom_range(99) < 50,
                 $urandom_range(99) < 3, $urandom_range(199) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
